// File: rtl/wu_decode_pkg.sv
// Shared constants for the work-unit decode stage: option types, FSM states,
// delineator encodings and the default option field geometry.
package wu_decode_pkg;

  localparam int unsigned OPT_PER_INST_DEF = 32'd3;
  localparam int unsigned OPT_TYPE_W_DEF   = 32'd8;
  localparam int unsigned OPT_VALUE_W_DEF  = 32'd8;

  localparam int unsigned OPT_NOP       = 32'd0;
  localparam int unsigned OPT_OP        = 32'd1;
  localparam int unsigned OPT_NUM_LANES = 32'd2;
  localparam int unsigned OPT_STRIDE    = 32'd3;
  localparam int unsigned OPT_TAG       = 32'd4;

  localparam logic [1:0] DL_MOM     = 2'b00;
  localparam logic [1:0] DL_SOM     = 2'b01;
  localparam logic [1:0] DL_EOM     = 2'b10;
  localparam logic [1:0] DL_SOM_EOM = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;

  function automatic logic dl_starts(input logic [1:0] dl);
    return (dl == DL_SOM) || (dl == DL_SOM_EOM);
  endfunction

  function automatic logic dl_ends(input logic [1:0] dl);
    return (dl == DL_EOM) || (dl == DL_SOM_EOM);
  endfunction

endpackage

// File: rtl/wud_fifo.sv
// Generic synchronous FIFO with a registered count and a registered
// almost-full flag; writes while full are dropped and flagged.
module wud_fifo #(
  parameter int unsigned DW       = 32'd8,
  parameter int unsigned DEPTH    = 32'd4,
  parameter int unsigned AF_LEVEL = 32'd2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          empty_o,
  output logic          almost_full_o,
  output logic          overflow_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          af_q, af_d, push_s, pop_s, full_s;

  // Next-state pointers, count and almost-full level.
  always_comb begin
    full_s   = (count_q == (AW+1)'(DEPTH));
    push_s   = wr_en_i & ~full_s;
    pop_s    = rd_en_i & (count_q != '0);
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(32'd1)) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + AW'(32'd1)) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
    af_d     = (count_d >= (AW+1)'(AF_LEVEL));
  end

  // Storage and control registers; reset flushes the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      if (push_s) mem_q[wr_ptr_q] <= wr_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
    end
  end

  assign rd_data_o     = mem_q[rd_ptr_q];
  assign empty_o       = (count_q == '0);
  assign almost_full_o = af_q;
  assign overflow_o    = wr_en_i & full_s;

endmodule

// File: rtl/wu_decode.sv
// Work-unit decode: buffers option words from wu_memory and folds each
// SOM..EOM instruction into one registered record handed to mcntl.
module wu_decode
  import wu_decode_pkg::*;
#(
  parameter int unsigned OPT_PER_INST = OPT_PER_INST_DEF,
  parameter int unsigned OPT_TYPE_W   = OPT_TYPE_W_DEF,
  parameter int unsigned OPT_VALUE_W  = OPT_VALUE_W_DEF,
  parameter int unsigned FIFO_DEPTH   = 32'd4,
  parameter int unsigned SKID         = 32'd2
) (
  input  logic                                clk,
  input  logic                                reset_poweron,
  input  logic                                wum__wud__valid,
  input  logic [1:0]                          wum__wud__icntl,
  input  logic [1:0]                          wum__wud__dcntl,
  input  logic [OPT_PER_INST*OPT_TYPE_W-1:0]  wum__wud__option_type,
  input  logic [OPT_PER_INST*OPT_VALUE_W-1:0] wum__wud__option_value,
  output logic                                wud__wuf__stall,
  output logic                                wud__mcntl__valid,
  input  logic                                mcntl__wud__ready,
  output logic [OPT_VALUE_W-1:0]              wud__mcntl__op,
  output logic [OPT_VALUE_W-1:0]              wud__mcntl__num_lanes,
  output logic [OPT_VALUE_W-1:0]              wud__mcntl__stride,
  output logic [OPT_VALUE_W-1:0]              wud__mcntl__tag,
  output logic [3:0]                          wud__mcntl__num_desc,
  output logic                                wud__mcntl__opt_err,
  output logic                                wud__mcntl__proto_err
);
  localparam int unsigned TY_W   = OPT_PER_INST * OPT_TYPE_W;
  localparam int unsigned VA_W   = OPT_PER_INST * OPT_VALUE_W;
  localparam int unsigned WORD_W = 32'd4 + TY_W + VA_W;

  logic [WORD_W-1:0]      wr_word_s, head_s;
  logic [1:0]             head_ic_s, head_dc_s;
  logic [TY_W-1:0]        head_ty_s;
  logic [VA_W-1:0]        head_va_s;
  logic                   empty_s, ovf_s, pop_s, start_s, end_s;
  logic [1:0]             state_q, state_d;
  logic                   valid_q, valid_d, perr_q, perr_d, bubble_q, bubble_d;
  logic [OPT_VALUE_W-1:0] op_q, op_d, lanes_q, lanes_d, stride_q, stride_d, tag_q, tag_d;
  logic [OPT_VALUE_W-1:0] m_op_s, m_lanes_s, m_stride_s, m_tag_s;
  logic [3:0]             nd_q, nd_d, m_nd_s;
  logic                   oerr_q, oerr_d, m_oerr_s;

  assign wr_word_s = {wum__wud__icntl, wum__wud__dcntl, wum__wud__option_type, wum__wud__option_value};

  wud_fifo #(
    .DW      (WORD_W),
    .DEPTH   (FIFO_DEPTH),
    .AF_LEVEL(FIFO_DEPTH - SKID)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (reset_poweron),
    .wr_en_i      (wum__wud__valid),
    .wr_data_i    (wr_word_s),
    .rd_en_i      (pop_s),
    .rd_data_o    (head_s),
    .empty_o      (empty_s),
    .almost_full_o(wud__wuf__stall),
    .overflow_o   (ovf_s)
  );

  assign head_ic_s = head_s[WORD_W-1 -: 2];
  assign head_dc_s = head_s[WORD_W-3 -: 2];
  assign head_ty_s = head_s[TY_W+VA_W-1 -: TY_W];
  assign head_va_s = head_s[VA_W-1:0];
  assign start_s   = dl_starts(head_ic_s);
  assign end_s     = dl_ends(head_ic_s);

  // Merge the head word onto the current record (cleared first on a start word).
  always_comb begin
    if (start_s) begin
      m_op_s = '0; m_lanes_s = '0; m_stride_s = '0; m_tag_s = '0; m_nd_s = 4'd0; m_oerr_s = 1'b0;
    end else begin
      m_op_s = op_q; m_lanes_s = lanes_q; m_stride_s = stride_q; m_tag_s = tag_q;
      m_nd_s = nd_q; m_oerr_s = oerr_q;
    end
    for (int i = 0; i < int'(OPT_PER_INST); i++) begin
      case (head_ty_s[i*OPT_TYPE_W +: OPT_TYPE_W])
        OPT_TYPE_W'(OPT_NOP):       m_oerr_s   = m_oerr_s;
        OPT_TYPE_W'(OPT_OP):        m_op_s     = head_va_s[i*OPT_VALUE_W +: OPT_VALUE_W];
        OPT_TYPE_W'(OPT_NUM_LANES): m_lanes_s  = head_va_s[i*OPT_VALUE_W +: OPT_VALUE_W];
        OPT_TYPE_W'(OPT_STRIDE):    m_stride_s = head_va_s[i*OPT_VALUE_W +: OPT_VALUE_W];
        OPT_TYPE_W'(OPT_TAG):       m_tag_s    = head_va_s[i*OPT_VALUE_W +: OPT_VALUE_W];
        default:                    m_oerr_s   = 1'b1;
      endcase
    end
    if (dl_starts(head_dc_s) && (m_nd_s != 4'd15)) begin
      m_nd_s = m_nd_s + 4'd1;
    end else begin
      m_nd_s = m_nd_s;
    end
  end

  // Decode FSM; a one-cycle bubble follows each accepted record before popping resumes.
  always_comb begin
    state_d = state_q; op_d = op_q; lanes_d = lanes_q; stride_d = stride_q; tag_d = tag_q;
    nd_d = nd_q; oerr_d = oerr_q; pop_s = 1'b0; bubble_d = 1'b0; perr_d = ovf_s;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (!empty_s && !bubble_q) begin
          pop_s = 1'b1;
          if (start_s || (state_q == ST_ACCUM)) begin
            op_d = m_op_s; lanes_d = m_lanes_s; stride_d = m_stride_s; tag_d = m_tag_s;
            nd_d = m_nd_s; oerr_d = m_oerr_s;
            state_d = end_s ? ST_EMIT : ST_ACCUM;
            perr_d = ovf_s | (start_s & (state_q == ST_ACCUM));
          end else begin
            perr_d = 1'b1;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_EMIT: begin
        if (mcntl__wud__ready) begin
          state_d  = ST_IDLE;
          bubble_d = 1'b1;
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_EMIT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q <= ST_IDLE; valid_q <= 1'b0; perr_q <= 1'b0; bubble_q <= 1'b0;
      op_q <= '0; lanes_q <= '0; stride_q <= '0; tag_q <= '0; nd_q <= 4'd0; oerr_q <= 1'b0;
    end else begin
      state_q <= state_d; valid_q <= valid_d; perr_q <= perr_d; bubble_q <= bubble_d;
      op_q <= op_d; lanes_q <= lanes_d; stride_q <= stride_d; tag_q <= tag_d;
      nd_q <= nd_d; oerr_q <= oerr_d;
    end
  end

  assign wud__mcntl__valid     = valid_q;
  assign wud__mcntl__op        = op_q;
  assign wud__mcntl__num_lanes = lanes_q;
  assign wud__mcntl__stride    = stride_q;
  assign wud__mcntl__tag       = tag_q;
  assign wud__mcntl__num_desc  = nd_q;
  assign wud__mcntl__opt_err   = oerr_q;
  assign wud__mcntl__proto_err = perr_q;

endmodule

// File: tb/tb_wu_decode.sv
// Scoreboard bench for wu_decode: expected records are queued as stimulus is
// driven and compared when mcntl accepts a record.
`timescale 1ns/1ps
module tb_wu_decode;
  import wu_decode_pkg::*;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] lanes;
    logic [7:0] stride;
    logic [7:0] tag;
    logic [3:0] nd;
    logic       oe;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_ic = 2'b00, in_dc = 2'b00;
  logic [23:0] in_ty = 24'd0, in_va = 24'd0;
  logic        ready = 1'b0;
  logic        stall, valid, opt_err, proto_err;
  logic [7:0]  op, lanes, stride, tag;
  logic [3:0]  num_desc;
  rec_t        cur_s;

  int   cyc = 0, n_checks = 0, n_errors = 0, perr_cnt = 0, acc_cnt = 0, last_acc = -1;
  int   p0, a0;
  bit   gap_en = 1'b0, hold_v = 1'b0;
  logic last_stall;
  rec_t hold_rec, exp_rec;
  rec_t sb[$];

  wu_decode dut (
    .clk                   (clk),
    .reset_poweron         (rst_n),
    .wum__wud__valid       (in_valid),
    .wum__wud__icntl       (in_ic),
    .wum__wud__dcntl       (in_dc),
    .wum__wud__option_type (in_ty),
    .wum__wud__option_value(in_va),
    .wud__wuf__stall       (stall),
    .wud__mcntl__valid     (valid),
    .mcntl__wud__ready     (ready),
    .wud__mcntl__op        (op),
    .wud__mcntl__num_lanes (lanes),
    .wud__mcntl__stride    (stride),
    .wud__mcntl__tag       (tag),
    .wud__mcntl__num_desc  (num_desc),
    .wud__mcntl__opt_err   (opt_err),
    .wud__mcntl__proto_err (proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign cur_s = {op, lanes, stride, tag, num_desc, opt_err};

  task automatic check_eq(input string tag_s, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag_s, got, exp);
    end
  endtask

  // Drive one word for one cycle; entered and left just after a rising edge.
  task automatic send(input logic [1:0] ic, input logic [1:0] dc,
                      input logic [23:0] ty, input logic [23:0] va);
    in_valid = 1'b1; in_ic = ic; in_dc = dc; in_ty = ty; in_va = va;
    @(negedge clk);
    last_stall = stall;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int i = 0;
    while (sb.size() != 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic rec_t mk(input logic [7:0] o, input logic [7:0] l, input logic [7:0] s,
                              input logic [7:0] t, input logic [3:0] n, input logic e);
    return {o, l, s, t, n, e};
  endfunction

  // Output monitor: hold stability, throughput gaps, scoreboard compare.
  always @(negedge clk) begin
    if (proto_err) perr_cnt++;
    if (hold_v && valid) check_eq("hold", 64'(cur_s), 64'(hold_rec));
    hold_v   = valid && !ready;
    hold_rec = cur_s;
    if (valid && ready) begin
      acc_cnt++;
      if (gap_en && last_acc >= 0) check_eq("gap", 64'(cyc - last_acc), 64'd3);
      last_acc = cyc;
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 64'(sb.size()), 64'd1);
      end else begin
        exp_rec = sb.pop_front();
        check_eq("op", 64'(op), 64'(exp_rec.op));
        check_eq("num_lanes", 64'(lanes), 64'(exp_rec.lanes));
        check_eq("stride", 64'(stride), 64'(exp_rec.stride));
        check_eq("tag", 64'(tag), 64'(exp_rec.tag));
        check_eq("num_desc", 64'(num_desc), 64'(exp_rec.nd));
        check_eq("opt_err", 64'(opt_err), 64'(exp_rec.oe));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 64'(valid), 64'd0);
    check_eq("rst_fields", 64'(cur_s), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_perr", 64'(proto_err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single-word instruction and its latency.
    ready = 1'b1;
    sb.push_back(mk(8'h21, 8'd4, 8'd8, 8'd0, 4'd1, 1'b0));
    send(DL_SOM_EOM, DL_SOM_EOM, {8'd3, 8'd2, 8'd1}, {8'h08, 8'h04, 8'h21});
    @(negedge clk);
    check_eq("lat_t1", 64'(valid), 64'd0);
    @(negedge clk);
    check_eq("lat_t2", 64'(valid), 64'd1);
    wait_drain();

    // Three-word instruction with overrides and an unknown type.
    sb.push_back(mk(8'h11, 8'd0, 8'd0, 8'h07, 4'd2, 1'b1));
    send(DL_SOM, DL_SOM, {8'd1, 8'd0, 8'd1}, {8'h10, 8'h00, 8'h99});
    send(DL_MOM, DL_SOM_EOM, {8'd0, 8'd9, 8'd1}, {8'h00, 8'h55, 8'h11});
    send(DL_EOM, DL_EOM, {8'd0, 8'd0, 8'd4}, {8'h00, 8'h00, 8'h07});
    wait_drain();
    check_eq("no_perr", 64'(perr_cnt), 64'd0);

    // num_desc saturation: 18 descriptor starts.
    sb.push_back(mk(8'h5a, 8'd0, 8'd0, 8'd0, 4'd15, 1'b0));
    send(DL_SOM, DL_SOM, {8'd0, 8'd0, 8'd1}, {8'h00, 8'h00, 8'h5a});
    for (int k = 0; k < 16; k++) send(DL_MOM, DL_SOM, 24'd0, 24'd0);
    send(DL_EOM, DL_SOM, 24'd0, 24'd0);
    wait_drain();

    // Back-pressure: four instructions queued behind ready=0.
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sb.push_back(mk(8'h40 + 8'(k), 8'd0, 8'd0, 8'(k), 4'd1, 1'b0));
      send(DL_SOM_EOM, DL_SOM_EOM, {8'd4, 8'd0, 8'd1}, {8'(k), 8'h00, 8'h40 + 8'(k)});
      if (k == 2) check_eq("stall_low", 64'(last_stall), 64'd0);
      if (k == 3) check_eq("stall_high", 64'(last_stall), 64'd1);
    end
    repeat (6) @(posedge clk);
    #1;
    gap_en = 1'b1;
    last_acc = -1;
    ready = 1'b1;
    wait_drain();
    gap_en = 1'b0;
    @(negedge clk);
    check_eq("stall_clear", 64'(stall), 64'd0);
    @(posedge clk);
    #1;

    // Protocol errors.
    p0 = perr_cnt;
    a0 = acc_cnt;
    send(DL_EOM, DL_EOM, {8'd0, 8'd0, 8'd1}, {8'h00, 8'h00, 8'h22});
    repeat (4) @(negedge clk);
    check_eq("eom_idle_perr", 64'(perr_cnt - p0), 64'd1);
    check_eq("eom_idle_novalid", 64'(acc_cnt - a0), 64'd0);
    @(posedge clk);
    #1;
    sb.push_back(mk(8'h44, 8'd0, 8'd0, 8'd0, 4'd1, 1'b0));
    send(DL_SOM, DL_SOM, {8'd0, 8'd0, 8'd1}, {8'h00, 8'h00, 8'h33});
    send(DL_SOM_EOM, DL_SOM_EOM, {8'd0, 8'd0, 8'd1}, {8'h00, 8'h00, 8'h44});
    wait_drain();
    check_eq("som_accum_perr", 64'(perr_cnt - p0), 64'd2);
    check_eq("som_accum_one", 64'(acc_cnt - a0), 64'd1);

    // Reset during ACCUM.
    a0 = acc_cnt;
    send(DL_SOM, DL_SOM, {8'd0, 8'd0, 8'd1}, {8'h00, 8'h00, 8'h66});
    send(DL_MOM, DL_MOM, {8'd0, 8'd0, 8'd4}, {8'h00, 8'h00, 8'h01});
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_fields", 64'(cur_s), 64'd0);
    check_eq("mid_rst_valid", 64'(valid), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(DL_EOM, DL_EOM, {8'd0, 8'd0, 8'd2}, {8'h00, 8'h00, 8'h03});
    repeat (6) @(negedge clk);
    check_eq("post_rst_novalid", 64'(acc_cnt - a0), 64'd0);
    check_eq("post_rst_valid_low", 64'(valid), 64'd0);
    @(posedge clk);
    #1;
    sb.push_back(mk(8'h77, 8'd0, 8'd0, 8'd0, 4'd1, 1'b0));
    send(DL_SOM_EOM, DL_SOM_EOM, {8'd0, 8'd0, 8'd1}, {8'h00, 8'h00, 8'h77});
    wait_drain();
    check_eq("post_rst_one", 64'(acc_cnt - a0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
